cache_controller: RTL and testbench
===================================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 Parameter LEN_ADR, 15, word-address width; tag = adr[14:12], index = adr[11:2], word select = adr[1:0].
REQ-002 Parameter CNT_W, 16, width of each statistics counter.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low: sampled only on rising clk, 0 = reset.
REQ-005 cpu_req  input  1  CPU read request; sampled only in IDLE.
REQ-006 cpu_adr  input  LEN_ADR  CPU word address; valid with cpu_req.
REQ-007 cpu_ready  output  1  one-cycle pulse: cache o_data holds the requested word.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 cache_adr  output  LEN_ADR  address driven to the cache; equals the latched request address.
REQ-010 cache_write  output  1  block-fill strobe to the cache.
REQ-011 cache_hit  input  1  combinational hit flag from the cache for cache_adr.
REQ-012 mem_read  output  1  block-read request to main memory; level, held until accepted.
REQ-013 mem_adr  output  LEN_ADR-2  block address to memory = latched adr[14:2].
REQ-014 mem_ready  input  1  memory's 128-bit block (wired straight to the cache i_data) is valid.
REQ-015 hit_count  output  CNT_W  number of completed hits.
REQ-016 miss_count  output  CNT_W  number of completed misses.

Function
REQ-017 States: IDLE, LOOKUP, FETCH, FILL, DONE; encoded as a 3-bit state register.
REQ-018 IDLE: cpu_req=1 latches cpu_adr into adr_q, next state LOOKUP; cpu_req=0 stays IDLE.
REQ-019 LOOKUP: cache_hit=1 -> DONE with hit_count+1; cache_hit=0 -> FETCH with miss_count+1.
REQ-020 FETCH: mem_read=1; mem_ready=1 -> FILL; otherwise stay, with mem_read held and mem_adr stable.
REQ-021 FILL: cache_write=1 for exactly one cycle; next state DONE unconditionally.
REQ-022 DONE: cpu_ready=1 for exactly one cycle; next state IDLE.
REQ-023 Latency from cpu_req sampled in IDLE: hit -> cpu_ready 2 cycles later; miss -> cpu_ready N+3 cycles later, where N = FETCH cycles before mem_ready.
REQ-024 cpu_req outside IDLE is ignored and not queued; back-to-back requests have at least one IDLE cycle between them.
REQ-025 cpu_adr changes outside IDLE have no effect; cache_adr and mem_adr come from adr_q only.
REQ-026 mem_ready outside FETCH is ignored.
REQ-027 cache_write, mem_read and cpu_ready are registered-state decodes: mutually exclusive and glitch-free per state.
REQ-028 Counters saturate at 2^CNT_W-1 and never wrap.
REQ-029 A hit and a miss are never counted for the same request; each request increments exactly one counter.

Reset
REQ-030 rst=0 at a rising edge forces IDLE, adr_q=0, hit_count=0, miss_count=0, whatever the current state.
REQ-031 While in reset, cpu_ready, busy, cache_write and mem_read are 0, and cache_adr=0, mem_adr=0.
REQ-032 Reset during FETCH drops mem_read the next cycle; a late mem_ready is ignored and no fill occurs.
REQ-033 A cpu_req present in the first cycle after rst returns to 1 is accepted normally.

Structure
REQ-034 LEN_ADR, the tag/index/word field bounds and the state encodings live in the shared defs include file.
REQ-035 One sub-module, sat_counter (parameter CNT_W; ports clk, rst, inc, count), is instantiated twice, once for hits and once for misses.
REQ-036 The data path (128-bit memory block to cache i_data, cache o_data to CPU) stays outside this block; it carries only control and addresses.

Verification
REQ-037 Cold miss: reset, cpu_req with adr 15'd10, mem_ready held 0 for 3 cycles then 1 -> mem_adr=13'd2, exactly one cache_write cycle, cpu_ready 6 cycles after the request, miss_count=1.
REQ-038 Re-read of adr 15'd10 after the fill (cache model returns hit) -> cpu_ready 2 cycles after the request, no mem_read, hit_count=1.
REQ-039 Conflict: adr 15'h100A (same index, tag 1) after the adr 10 fill -> miss, mem_adr=13'h402, miss_count=2.
REQ-040 Reset asserted in the 2nd FETCH cycle, mem_ready pulsed on the next cycle -> IDLE, no cache_write, counters 0.
REQ-041 cpu_req held high continuously -> requests accepted only in IDLE; cpu_ready pulses separated by at least one IDLE cycle; counter sum equals the number of pulses.
REQ-042 Counters preloaded to 16'hFFFE via the hit path, then 3 hits -> hit_count stays at 16'hFFFF.

Source files
------------

// File: rtl/cache_controller_pkg.sv
// Shared definitions for the cache controller: address field bounds, default
// widths and the controller state encoding.
package cache_controller_pkg;

    localparam int LEN_ADR_DEF = 15;
    localparam int CNT_W_DEF   = 16;

    // Word-address fields: tag | index | word select
    localparam int TAG_HI = 14;
    localparam int TAG_LO = 12;
    localparam int IDX_HI = 11;
    localparam int IDX_LO = 2;
    localparam int WRD_HI = 1;
    localparam int WRD_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FETCH  = 3'd2,
        ST_FILL   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/cache_controller_if.sv
// Control/address bundle between the cache controller, the CPU, the cache
// array and main memory.
//   master : environment side (drives cpu_req, cpu_adr, cache_hit, mem_ready)
//   slave  : controller side (drives cpu_ready, busy, cache_adr, cache_write,
//            mem_read, mem_adr)
interface cache_controller_if
    import cache_controller_pkg::*;
#(
    parameter int LEN_ADR = LEN_ADR_DEF
);
    logic               cpu_req;
    logic [LEN_ADR-1:0] cpu_adr;
    logic               cpu_ready;
    logic               busy;
    logic [LEN_ADR-1:0] cache_adr;
    logic               cache_write;
    logic               cache_hit;
    logic               mem_read;
    logic [LEN_ADR-3:0] mem_adr;
    logic               mem_ready;

    modport master (
        output cpu_req, cpu_adr, cache_hit, mem_ready,
        input  cpu_ready, busy, cache_adr, cache_write, mem_read, mem_adr
    );

    modport slave (
        input  cpu_req, cpu_adr, cache_hit, mem_ready,
        output cpu_ready, busy, cache_adr, cache_write, mem_read, mem_adr
    );

endinterface

// File: rtl/cache_controller_sat_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones.
//   clk   : clock
//   rst   : synchronous active-low reset, clears the count
//   inc   : count one event this cycle
//   count : current value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cache_controller.sv
// Read-miss controller for a direct-mapped cache. Latches a CPU request,
// checks the cache, fetches the block from memory on a miss, fills the cache
// and signals the CPU. Data never passes through here, only control/addresses.
//   clk        : clock
//   rst        : synchronous active-low reset
//   bus        : slave side of cache_controller_if
//   hit_count  : completed hits (saturating)
//   miss_count : completed misses (saturating)
//
// state  | meaning
// IDLE   | waiting for cpu_req, latch address
// LOOKUP | cache_hit evaluated for the latched address
// FETCH  | mem_read held until mem_ready
// FILL   | one-cycle cache_write of the returned block
// DONE   | one-cycle cpu_ready
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int LEN_ADR = LEN_ADR_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    cache_controller_if.slave bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    state_t             state_q, state_d;
    logic [LEN_ADR-1:0] adr_q, adr_d;
    logic               cpu_ready_q, cpu_ready_d;
    logic               busy_q, busy_d;
    logic               cache_write_q, cache_write_d;
    logic               mem_read_q, mem_read_d;
    logic               hit_inc;
    logic               miss_inc;

    always_comb begin
        state_d  = state_q;
        adr_d    = adr_q;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    adr_d   = bus.cpu_adr;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (bus.cache_hit) begin
                    hit_inc = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    miss_inc = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL:  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so each is
        // a clean flop that is high exactly while the FSM sits in its state.
        cpu_ready_d   = (state_d == ST_DONE);
        busy_d        = (state_d != ST_IDLE);
        cache_write_d = (state_d == ST_FILL);
        mem_read_d    = (state_d == ST_FETCH);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            adr_q         <= '0;
            cpu_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            cache_write_q <= 1'b0;
            mem_read_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            adr_q         <= adr_d;
            cpu_ready_q   <= cpu_ready_d;
            busy_q        <= busy_d;
            cache_write_q <= cache_write_d;
            mem_read_q    <= mem_read_d;
        end
    end

    assign bus.cpu_ready   = cpu_ready_q;
    assign bus.busy        = busy_q;
    assign bus.cache_write = cache_write_q;
    assign bus.mem_read    = mem_read_q;
    assign bus.cache_adr   = adr_q;
    assign bus.mem_adr     = adr_q[LEN_ADR-1:IDX_LO];

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;
    import cache_controller_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] hit_count, miss_count;
    logic [1:0]  hit2, miss2;

    cache_controller_if #(.LEN_ADR(15)) bif ();
    cache_controller_if #(.LEN_ADR(15)) bif2 ();

    cache_controller #(.LEN_ADR(15), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif.slave),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    // Narrow-counter instance used to exercise saturation in reasonable time.
    cache_controller #(.LEN_ADR(15), .CNT_W(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .bus        (bif2.slave),
        .hit_count  (hit2),
        .miss_count (miss2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int req_cyc;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   mr_cnt   = 0;
    int   wr_cnt   = 0;
    int   pulses   = 0;
    int   exp_hits = 0;
    int   exp_miss = 0;
    bit   cont_mode = 0;
    bit   idle_seen = 1;

    // Environment cache model: valid/tag per index, filled on cache_write.
    bit       valid_m [1024];
    bit [2:0] tag_m   [1024];

    assign bif.cache_hit = valid_m[bif.cache_adr[11:2]] &&
                           (tag_m[bif.cache_adr[11:2]] == bif.cache_adr[14:12]);

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: sampled mid-cycle, away from the active edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            check("excl", 32'((32'(bif.cache_write) + 32'(bif.mem_read) + 32'(bif.cpu_ready)) <= 1), 32'd1);
            if (bif.mem_read) mr_cnt++;
            if (bif.cache_write) begin
                wr_cnt++;
                valid_m[bif.cache_adr[11:2]] = 1'b1;
                tag_m[bif.cache_adr[11:2]]   = bif.cache_adr[14:12];
            end
            if (!bif.busy) idle_seen = 1;
            if (bif.cpu_ready) begin
                check("idle_gap", 32'(idle_seen), 32'd1);
                idle_seen = 0;
                pulses++;
                if (!cont_mode) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_ready", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("latency", 32'(cyc - e.req_cyc), 32'(e.lat));
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        for (int t = 0; t < 20 && bif.busy; t++) begin
            @(posedge clk); #1;
        end
        if (bif.busy) check({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hits"}, 32'(hit_count), 32'(exp_hits));
        check({tag, "_miss"}, 32'(miss_count), 32'(exp_miss));
    endtask

    task automatic do_req(input logic [14:0] adr, input bit hit, input int n);
        exp_t e;
        int   mr0, wr0;
        @(posedge clk); #1;
        mr0 = mr_cnt;
        wr0 = wr_cnt;
        bif.cpu_req = 1'b1;
        bif.cpu_adr = adr;
        e.req_cyc   = cyc;
        e.lat       = hit ? 2 : n + 3;
        exp_q.push_back(e);
        @(posedge clk); #1;
        bif.cpu_req = 1'b0;
        bif.cpu_adr = 15'($urandom);
        check("lookup_adr", 32'(bif.cache_adr), 32'(adr));
        if (hit) begin
            exp_hits++;
            bif.mem_ready = 1'b1;
            @(posedge clk); #1;
            bif.mem_ready = 1'b0;
        end else begin
            exp_miss++;
            for (int k = 1; k <= n; k++) begin
                @(posedge clk); #1;
                bif.mem_ready = (k == n);
                check("mem_read", 32'(bif.mem_read), 32'd1);
                check("mem_adr", 32'(bif.mem_adr), 32'(adr[14:2]));
            end
            @(posedge clk); #1;
            bif.mem_ready = 1'b0;
        end
        wait_idle("req");
        check("mem_read_cycles", 32'(mr_cnt - mr0), hit ? 32'd0 : 32'(n));
        check("fill_cycles", 32'(wr_cnt - wr0), hit ? 32'd0 : 32'd1);
        check_counters("req");
    endtask

    initial begin
        int p0, h0, wr0;
        exp_t e;
        rst           = 1'b0;
        bif.cpu_req   = 1'b0;
        bif.cpu_adr   = '0;
        bif.mem_ready = 1'b0;
        bif2.cpu_req   = 1'b0;
        bif2.cpu_adr   = '0;
        bif2.cache_hit = 1'b0;
        bif2.mem_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bif.busy), 32'd0);
        check("rst_ready", 32'(bif.cpu_ready), 32'd0);
        check("rst_mem_read", 32'(bif.mem_read), 32'd0);
        check("rst_cache_adr", 32'(bif.cache_adr), 32'd0);
        check_counters("rst");
        rst = 1'b1;

        // adr, expected hit, FETCH cycles
        do_req(15'd10,    1'b0, 3);
        do_req(15'd10,    1'b1, 0);
        do_req(15'h100A,  1'b0, 1);
        do_req(15'd10,    1'b0, 2);
        do_req(15'd11,    1'b1, 0);
        do_req(15'h7FFF,  1'b0, 4);
        do_req(15'h7FFC,  1'b1, 0);
        do_req(15'd0,     1'b0, 1);

        // Reset in the 2nd FETCH cycle, late mem_ready, request right after.
        wr0 = wr_cnt;
        @(posedge clk); #1;
        bif.cpu_req = 1'b1;
        bif.cpu_adr = 15'h2344;
        @(posedge clk); #1;
        bif.cpu_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("fetch2_mem_read", 32'(bif.mem_read), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        bif.mem_ready = 1'b1;
        check("inrst_busy", 32'(bif.busy), 32'd0);
        check("inrst_mem_read", 32'(bif.mem_read), 32'd0);
        check("inrst_write", 32'(bif.cache_write), 32'd0);
        check("inrst_ready", 32'(bif.cpu_ready), 32'd0);
        check("inrst_cache_adr", 32'(bif.cache_adr), 32'd0);
        check("inrst_mem_adr", 32'(bif.mem_adr), 32'd0);
        exp_hits = 0;
        exp_miss = 0;
        check_counters("inrst");
        @(posedge clk); #1;
        rst           = 1'b1;
        bif.mem_ready = 1'b0;
        bif.cpu_req   = 1'b1;
        bif.cpu_adr   = 15'd10;
        e.req_cyc = cyc;
        e.lat     = 2;
        exp_q.push_back(e);
        exp_hits++;
        @(posedge clk); #1;
        bif.cpu_req = 1'b0;
        wait_idle("post_rst");
        check("post_rst_no_fill", 32'(wr_cnt - wr0), 32'd0);
        check_counters("post_rst");

        // cpu_req held high continuously.
        @(posedge clk); #1;
        cont_mode = 1;
        p0 = pulses;
        h0 = hit_count;
        bif.cpu_req = 1'b1;
        bif.cpu_adr = 15'd10;
        repeat (30) @(posedge clk);
        #1;
        bif.cpu_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        cont_mode = 0;
        check("cont_pulses", 32'(pulses - p0), 32'd10);
        check("cont_sum", 32'(hit_count - 16'(h0)), 32'(pulses - p0));
        exp_hits += 10;
        check_counters("cont");

        // Saturation on the narrow instance.
        bif2.cache_hit = 1'b1;
        bif2.cpu_req   = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("sat_hit_2", 32'(hit2), 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("sat_hit_3", 32'(hit2), 32'd3);
        repeat (21) @(posedge clk);
        #1;
        bif2.cpu_req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_hit_hold", 32'(hit2), 32'd3);
        bif2.cache_hit = 1'b0;
        bif2.cpu_req   = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        bif2.cpu_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("sat_miss_hold", 32'(miss2), 32'd3);
        check("sat_hit_final", 32'(hit2), 32'd3);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
